// File: rtl/ofs_plat_axi_mem_rsp_buffer.sv
// ---------------------------------------------------------------------------
// ofs_plat_axi_mem_rsp_buffer
//
// Buffers AXI R beats and B responses arriving from a memory device that has
// no response-side flow control, and re-presents them to the AFU-side source
// with standard valid/ready handshakes. Each channel is an independent FIFO
// built from a registered-read RAM, a read stage and an output register, so
// the source-facing payloads always come straight from flops.
//
// The upstream request-side credit limiter hands out exactly as many credits
// as these FIFOs hold, so a drop should never occur in a consistent system.
// Drops are still detected and latched in sticky overflow flags for debug.
//
// Ports (top):
//   clk, reset_n          clock, synchronous active-low reset
//   dev_rvalid, dev_r     device R beat (no ready exists)
//   dev_bvalid, dev_b     device B response (no ready exists)
//   src_rvalid/r/rready   buffered R channel towards the source
//   src_bvalid/b/bready   buffered B channel towards the source
//   rd_used, wr_used      entries held per channel, incl. output register
//   rd_overflow           sticky: an R beat was dropped
//   wr_overflow           sticky: a B response was dropped
//
// Ports (ofs_plat_axi_mem_rsp_buffer_fifo, one channel):
//   i_valid, i_data       incoming beat, no backpressure
//   o_valid, o_data       buffered beat, i_ready accepts it
//   o_used                entries held, 0..DEPTH
//   o_overflow            sticky drop flag
// ---------------------------------------------------------------------------

module ofs_plat_axi_mem_rsp_buffer_fifo #(
    parameter int WIDTH = 16,
    // Power of 2, at least 4.
    parameter int DEPTH = 128
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_valid,
    input  logic [WIDTH-1:0]           i_data,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_used,
    output logic                       o_overflow
);

    localparam int USED_W = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam logic [USED_W-1:0] DEPTH_U = USED_W'(DEPTH);

    logic [WIDTH-1:0]  r_ram [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic              r_stageValid;
    logic [WIDTH-1:0]  r_stageData;
    logic              r_outValid;
    logic [WIDTH-1:0]  r_outData;
    logic [USED_W-1:0] r_used;
    logic              r_overflow;

    logic              w_deq;
    logic              w_enq;
    logic              w_drop;
    logic              w_outLoad;
    logic              w_stageFree;
    logic [USED_W-1:0] w_inFlight;
    logic [USED_W-1:0] w_ramCount;
    logic              w_ramNotEmpty;
    logic              w_stageLoadRam;
    logic              w_stageLoadBypass;
    logic              w_ramWrite;

    // Entries still in the RAM are whatever the used count holds beyond the
    // read stage and the output register, so no separate RAM counter is kept.
    always_comb begin
        w_inFlight    = {{(USED_W-1){1'b0}}, r_stageValid} + {{(USED_W-1){1'b0}}, r_outValid};
        w_ramCount    = r_used - w_inFlight;
        w_ramNotEmpty = (w_ramCount != '0);

        w_deq  = r_outValid & i_ready;
        // A full FIFO can still take a beat when one leaves at the same edge.
        w_enq  = i_valid & ((r_used != DEPTH_U) | w_deq);
        w_drop = i_valid & ~w_enq;

        // The output register refills from the read stage whenever it is
        // empty or being drained, which keeps back-to-back beats bubble-free.
        w_outLoad   = r_stageValid & (~r_outValid | w_deq);
        w_stageFree = ~r_stageValid | w_outLoad;

        // With nothing waiting in the RAM, a new beat goes straight into the
        // read stage, giving exactly one cycle of bubble on an empty FIFO.
        w_stageLoadRam    = w_stageFree & w_ramNotEmpty;
        w_stageLoadBypass = w_stageFree & ~w_ramNotEmpty & w_enq;
        w_ramWrite        = w_enq & ~w_stageLoadBypass;
    end

    // Control state: pointers, valids, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_stageValid <= 1'b0;
            r_outValid   <= 1'b0;
            r_used       <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_ramWrite) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_stageLoadRam) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_stageFree) begin
                r_stageValid <= w_stageLoadRam | w_stageLoadBypass;
            end
            if (w_outLoad) begin
                r_outValid <= 1'b1;
            end else if (w_deq) begin
                r_outValid <= 1'b0;
            end
            if (w_enq && !w_deq) begin
                r_used <= r_used + USED_W'(1);
            end else if (!w_enq && w_deq) begin
                r_used <= r_used - USED_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Payload storage is never reset; the valids above qualify it.
    always_ff @(posedge clk) begin
        if (w_ramWrite) begin
            r_ram[r_wrPtr] <= i_data;
        end
        if (w_stageLoadRam) begin
            r_stageData <= r_ram[r_rdPtr];
        end else if (w_stageLoadBypass) begin
            r_stageData <= i_data;
        end
        if (w_outLoad) begin
            r_outData <= r_stageData;
        end
    end

    assign o_valid    = r_outValid;
    assign o_data     = r_outData;
    assign o_used     = r_used;
    assign o_overflow = r_overflow;

`ifndef SYNTHESIS
    // A drop means the credit limiter and this buffer disagree on depth.
    assert property (@(posedge clk) disable iff (!reset_n) !w_drop)
        else $warning("%m: FIFO full, incoming beat dropped");

    assert property (@(posedge clk) reset_n |-> !$isunknown(i_valid))
        else $error("%m: i_valid is X/Z out of reset");
`endif

endmodule

module ofs_plat_axi_mem_rsp_buffer #(
    parameter int R_WIDTH           = 512,
    parameter int B_WIDTH           = 16,
    parameter int NUM_READ_ENTRIES  = 256,
    parameter int NUM_WRITE_ENTRIES = 128
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   dev_rvalid,
    input  logic [R_WIDTH-1:0]                     dev_r,
    input  logic                                   dev_bvalid,
    input  logic [B_WIDTH-1:0]                     dev_b,
    output logic                                   src_rvalid,
    output logic [R_WIDTH-1:0]                     src_r,
    input  logic                                   src_rready,
    output logic                                   src_bvalid,
    output logic [B_WIDTH-1:0]                     src_b,
    input  logic                                   src_bready,
    output logic [$clog2(NUM_READ_ENTRIES+1)-1:0]  rd_used,
    output logic [$clog2(NUM_WRITE_ENTRIES+1)-1:0] wr_used,
    output logic                                   rd_overflow,
    output logic                                   wr_overflow
);

    // The two channels share nothing but the clock and reset.
    ofs_plat_axi_mem_rsp_buffer_fifo #(
        .WIDTH (R_WIDTH),
        .DEPTH (NUM_READ_ENTRIES)
    ) rFifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_valid    (dev_rvalid),
        .i_data     (dev_r),
        .o_valid    (src_rvalid),
        .o_data     (src_r),
        .i_ready    (src_rready),
        .o_used     (rd_used),
        .o_overflow (rd_overflow)
    );

    ofs_plat_axi_mem_rsp_buffer_fifo #(
        .WIDTH (B_WIDTH),
        .DEPTH (NUM_WRITE_ENTRIES)
    ) bFifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_valid    (dev_bvalid),
        .i_data     (dev_b),
        .o_valid    (src_bvalid),
        .o_data     (src_b),
        .i_ready    (src_bready),
        .o_used     (wr_used),
        .o_overflow (wr_overflow)
    );

endmodule
